// File: rtl/iq_demixer_decim.sv
// iq_demixer_decim: fs/4 quadrature demixer with integrate-and-dump decimation to a valid/ready I/Q output
module iq_demixer_decim #(
  parameter int DATA_W   = 16,
  parameter int DEC_LOG2 = 4,
  parameter int PHASE0   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_i,
  output logic signed [DATA_W-1:0] out_q,
  output logic                     overrun
);
  localparam int AW = DATA_W + DEC_LOG2;
  logic [1:0] phase;
  logic [DEC_LOG2-1:0] dec_cnt;
  logic signed [AW-1:0] acc_i, acc_q, sum_i, sum_q, shr_i, shr_q;
  logic signed [DATA_W:0] ext, p_i, p_q;
  logic dump;
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [AW-1:0] v);
    logic [AW-DATA_W:0] hi;
    hi = v[AW-1:DATA_W-1];
    return (&hi || ~|hi) ? v[DATA_W-1:0] : {v[AW-1], {(DATA_W-1){~v[AW-1]}}};
  endfunction
  // Widen before negation so -2^(W-1) maps to +2^(W-1) exactly
  always_comb begin
    ext = {in_data[DATA_W-1], in_data};
    p_i = phase == 2'd0 ? ext : phase == 2'd2 ? -ext : '0;
    p_q = phase == 2'd3 ? ext : phase == 2'd1 ? -ext : '0;
    sum_i = acc_i + AW'(p_i);
    sum_q = acc_q + AW'(p_q);
    shr_i = sum_i >>> (DEC_LOG2 - 1);
    shr_q = sum_q >>> (DEC_LOG2 - 1);
    dump = in_valid && &dec_cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 2'(PHASE0);
      dec_cnt   <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      overrun   <= 1'b0;
    end else if (clr) begin
      phase     <= 2'(PHASE0);
      dec_cnt   <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid) begin
        phase   <= phase + 2'd1;
        dec_cnt <= dump ? '0 : dec_cnt + 1'b1;
        acc_i   <= dump ? '0 : sum_i;
        acc_q   <= dump ? '0 : sum_q;
      end
      if (dump) begin
        out_i     <= sat(shr_i);
        out_q     <= sat(shr_q);
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_iq_demixer_decim.sv
// tb_iq_demixer_decim: randomized scoreboard bench against a plain-arithmetic demix/decimate model
module tb_iq_demixer_decim;
  logic clk = 0, rst = 1, clr = 0, in_valid = 0, out_ready = 1;
  logic signed [15:0] in_data = 0;
  logic out_valid, overrun;
  logic signed [15:0] out_i, out_q;
  typedef struct {int i; int q;} res_t;
  res_t sb[$];
  res_t mr;
  int errors = 0, checks = 0, n_hs = 0;
  int mph, mcnt, si, sq, n0;
  logic mon_en = 1;
  int cosw[4] = '{1000, 0, -1000, 0};
  int sinw[4] = '{0, 1000, 0, -1000};
  int extw[4] = '{32767, 0, -32768, 0};
  int ext2[4] = '{-32768, -32768, -32767, 32767};

  always #5 clk = ~clk;

  iq_demixer_decim #(.DATA_W(16), .DEC_LOG2(4), .PHASE0(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .overrun(overrun));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction

  task automatic model_reset();
    mph = 0; mcnt = 0; si = 0; sq = 0;
  endtask

  // LO: I = cos -> {+1,0,-1,0}, Q = -sin -> {0,-1,0,+1}; result = floor(sum*2/16)
  task automatic send(input int d);
    res_t r;
    in_valid = 1;
    in_data = 16'(d);
    case (mph)
      0: si += d;
      1: sq -= d;
      2: si -= d;
      default: sq += d;
    endcase
    mph = (mph + 1) % 4;
    mcnt++;
    if (mcnt == 16) begin
      r.i = sat(si >>> 3);
      r.q = sat(sq >>> 3);
      sb.push_back(r);
      mcnt = 0; si = 0; sq = 0;
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic block(input int w[4], input int scale, input bit gaps);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        send(w[k] * scale);
        if (gaps) idle($urandom_range(0, 2));
      end
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      n_hs++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got i=%0d q=%0d expected none", out_i, out_q);
      end else begin
        mr = sb.pop_front();
        chk("out_i", out_i, mr.i);
        chk("out_q", out_q, mr.q);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_i", out_i, 0);
    chk("rst_q", out_q, 0);
    chk("rst_overrun", overrun, 0);
    rst = 0;
    @(posedge clk); #1;
    n0 = n_hs;
    block(cosw, 1, 0);
    idle(3);
    chk("cos_pulses", n_hs - n0, 1);
    block(sinw, 1, 0);
    block('{1000, 1000, 1000, 1000}, 1, 1);
    block(extw, 1, 0);
    block(ext2, 1, 0);
    repeat (4)
      for (int k = 0; k < 16; k++) begin
        send($urandom_range(0, 65535) - 32768);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    idle(3);
    // accept of the held result coincides with the next dump
    out_ready = 0;
    for (int k = 0; k < 16; k++) send($urandom_range(0, 65535) - 32768);
    idle(2);
    chk("held_valid", out_valid, 1);
    for (int k = 0; k < 15; k++) send($urandom_range(0, 65535) - 32768);
    out_ready = 1;
    send($urandom_range(0, 65535) - 32768);
    idle(2);
    chk("coincide_overrun", overrun, 0);
    // backpressure across two dumps
    mon_en = 0;
    out_ready = 0;
    block(cosw, 1, 0);
    block(cosw, 2, 0);
    idle(1);
    chk("bp_overrun", overrun, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_i", out_i, 2000);
    sb.delete();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    model_reset();
    chk("clr_valid", out_valid, 0);
    chk("clr_i", out_i, 0);
    chk("clr_overrun", overrun, 0);
    out_ready = 1;
    mon_en = 1;
    // reset mid-block
    for (int k = 0; k < 7; k++) send(cosw[k % 4]);
    rst = 1;
    #2;
    chk("midrst_valid", out_valid, 0);
    model_reset();
    rst = 0;
    @(posedge clk); #1;
    block(cosw, 1, 0);
    idle(2);
    chk("midrst_i", out_i, 1000);
    // clr mid-block
    for (int k = 0; k < 5; k++) send(sinw[k % 4]);
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    model_reset();
    block(cosw, 1, 1);
    idle(3);
    chk("sb_empty", sb.size(), 0);
    chk("final_overrun", overrun, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
